// File: rtl/i3c_pkg.sv
// i3c_pkg: shared bus-state, rx-frame types and framer constants
package i3c_pkg;
  typedef struct packed {
    logic value;
    logic pos_edge;
    logic neg_edge;
  } line_state_t;
  typedef struct packed {
    line_state_t sda;
    line_state_t scl;
    logic        start_det;
    logic        rstart_det;
    logic        stop_det;
  } bus_state_t;
  typedef struct packed {
    logic [7:0] data;
    logic       ninth;
    logic       first;
    logic       rstart;
  } rx_frame_t;
  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_e;
  localparam int RxFrameBits = 9;
endpackage

// File: rtl/rx_holding_reg.sv
// rx_holding_reg: single-entry valid/ready frame register with sticky overflow
// Optional parity check on load when I3C_RX_PARITY_CHECK_EN is defined.
module rx_holding_reg
  import i3c_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  input  logic      push_i,
  input  rx_frame_t frame_i,
  input  logic      ready_i,
  input  logic      overflow_clr_i,
  output rx_frame_t frame_o,
  output logic      valid_o,
  output logic      overflow_o,
  output logic      parity_err_o,
  output logic      load_o
);
  rx_frame_t r_frame;
  logic      r_valid, r_overflow;
  assign load_o       = push_i && (!r_valid || ready_i);
  assign frame_o      = r_frame;
  assign valid_o      = r_valid;
  assign overflow_o   = r_overflow;
  // holding register: reload beats drain, flush empties
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_valid <= 1'b0;
      r_frame <= '0;
    end else if (load_o) begin
      r_valid <= 1'b1;
      r_frame <= frame_i;
    end else if (r_valid && ready_i) begin
      r_valid <= 1'b0;
      r_frame <= '0;
    end
  end
  // sticky overflow: a dropped frame wins over a same-cycle clear
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_overflow <= 1'b0;
    else if (push_i && !load_o) r_overflow <= 1'b1;
    else if (overflow_clr_i) r_overflow <= 1'b0;
  end
`ifdef I3C_RX_PARITY_CHECK_EN
  logic r_parity_err;
  assign parity_err_o = r_parity_err;
  // odd parity T-bit check; address frames carry ACK and are skipped
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) r_parity_err <= 1'b0;
    else if (load_o) r_parity_err <= !frame_i.first && (frame_i.ninth != ~^frame_i.data);
    else if (r_valid && ready_i) r_parity_err <= 1'b0;
  end
`else
  assign parity_err_o = 1'b0;
`endif
endmodule

// File: rtl/bus_rx_frame.sv
// bus_rx_frame: assembles 9-bit bus frames from bus_monitor state
// Define I3C_RX_PARITY_CHECK_EN to enable T-bit parity checking.
module bus_rx_frame
  import i3c_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  bus_state_t bus_i,
  output logic [7:0] data_o,
  output logic       ninth_o,
  output logic       first_o,
  output logic       rstart_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       abort_o,
  output logic       overflow_o,
  input  logic       overflow_clr_i,
  output logic       parity_err_o
);
  rx_state_e r_state, w_next;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_first_pend, r_rstart_pend, r_abort;
  logic       w_start, w_sample, w_last, w_push, w_abort, w_load, w_unused;
  rx_frame_t  w_frame, w_held;
  assign w_start  = bus_i.start_det || bus_i.rstart_det;
  assign w_unused = ^{bus_i.sda.pos_edge, bus_i.sda.neg_edge, bus_i.scl.value, bus_i.scl.neg_edge};
  // state register
  always_ff @(posedge clk_i) r_state <= !rst_ni ? RX_IDLE : w_next;
  // next state: disable > stop > start/Sr
  always_comb w_next = (!enable_i || bus_i.stop_det) ? RX_IDLE : w_start ? RX_SHIFT : r_state;
  // outputs: bit sampling, frame completion and abort detection
  always_comb begin
    w_sample = enable_i && !bus_i.stop_det && !w_start && r_state == RX_SHIFT && bus_i.scl.pos_edge;
    w_last   = r_cnt == 4'(RxFrameBits - 1);
    w_push   = w_sample && w_last;
    w_abort  = enable_i && r_state == RX_SHIFT && r_cnt != 4'd0 && (bus_i.stop_det || w_start);
    w_frame  = '{data: r_shift, ninth: bus_i.sda.value, first: r_first_pend,
                 rstart: r_rstart_pend && r_first_pend};
  end
  // bit counter, shifter and START/Sr markers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt         <= '0;
      r_shift       <= '0;
      r_first_pend  <= 1'b0;
      r_rstart_pend <= 1'b0;
      r_abort       <= 1'b0;
    end else begin
      r_abort <= w_abort;
      if (!enable_i || bus_i.stop_det) begin
        r_cnt         <= '0;
        r_first_pend  <= 1'b0;
        r_rstart_pend <= 1'b0;
      end else if (w_start) begin
        r_cnt         <= '0;
        r_first_pend  <= 1'b1;
        r_rstart_pend <= bus_i.rstart_det;
      end else if (w_sample) begin
        r_cnt        <= w_last ? 4'd0 : r_cnt + 4'd1;
        r_shift      <= w_last ? r_shift : {r_shift[6:0], bus_i.sda.value};
        r_first_pend <= r_first_pend && !(w_last && w_load);
      end
    end
  end
  rx_holding_reg u_hold (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (!enable_i),
    .push_i         (w_push),
    .frame_i        (w_frame),
    .ready_i        (ready_i),
    .overflow_clr_i (overflow_clr_i),
    .frame_o        (w_held),
    .valid_o        (valid_o),
    .overflow_o     (overflow_o),
    .parity_err_o   (parity_err_o),
    .load_o         (w_load)
  );
  assign data_o   = w_held.data;
  assign ninth_o  = w_held.ninth;
  assign first_o  = w_held.first;
  assign rstart_o = w_held.rstart;
  assign abort_o  = r_abort;
endmodule

// File: tb/tb_bus_rx_frame.sv
// tb_bus_rx_frame: scoreboard bench for bus_rx_frame
module tb_bus_rx_frame;
  import i3c_pkg::*;
  typedef struct packed {
    logic [7:0] d;
    logic       n, f, r, p;
  } exp_t;
`ifdef I3C_RX_PARITY_CHECK_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, enable = 1, ready = 0, ovf_clr = 0;
  bus_state_t bus = '0;
  logic [7:0] data_o;
  logic ninth_o, first_o, rstart_o, valid_o, abort_o, overflow_o, parity_err_o;
  int errors = 0, checks = 0;
  exp_t q[$];
  logic [7:0] b80 = 8'h80;

  always #5 clk = ~clk;

  bus_rx_frame dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .bus_i(bus),
    .data_o(data_o), .ninth_o(ninth_o), .first_o(first_o), .rstart_o(rstart_o),
    .valid_o(valid_o), .ready_i(ready), .abort_o(abort_o), .overflow_o(overflow_o),
    .overflow_clr_i(ovf_clr), .parity_err_o(parity_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sbit(input logic b);
    bus.sda.value    = b;
    bus.scl.pos_edge = 1'b1;
    tick();
    bus.scl.pos_edge = 1'b0;
    tick();
  endtask

  task automatic sbyte(input logic [7:0] d, input logic n);
    for (int i = 7; i >= 0; i--) sbit(d[i]);
    sbit(n);
  endtask

  task automatic start(input logic rs);
    bus.start_det  = !rs;
    bus.rstart_det = rs;
    tick();
    bus.start_det  = 1'b0;
    bus.rstart_det = 1'b0;
  endtask

  task automatic stop();
    bus.stop_det = 1'b1;
    tick();
    bus.stop_det = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic n, f, r, p);
    q.push_back('{d: d, n: n, f: f, r: r, p: p & PEN});
  endtask

  // monitor: every accepted frame is compared against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && valid_o && ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %0h expected none", data_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("frame", {data_o, ninth_o, first_o, rstart_o, parity_err_o}, {e.d, e.n, e.f, e.r, e.p});
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    tick(); tick();
    chk("reset_outs", {data_o, ninth_o, first_o, rstart_o, valid_o, abort_o, overflow_o, parity_err_o}, 0);
    rst_n = 1;
    tick();
    // basic frame with immediate accept
    ready = 1;
    start(0);
    expect_frame(8'hA5, 0, 1, 0, 0);
    sbyte(8'hA5, 0);
    chk("valid_one_cycle", valid_o, 0);
    stop();
    chk("no_abort_on_clean_stop", abort_o, 0);
    // Sr framing and parity
    start(1);
    expect_frame(8'h3C, 1, 1, 1, 0);
    sbyte(8'h3C, 1);
    expect_frame(8'h3C, 0, 0, 0, 1);
    sbyte(8'h3C, 0);
    stop();
    // partial frame abort
    start(0);
    for (int i = 0; i < 5; i++) sbit(1'b1);
    stop();
    chk("abort_pulse", abort_o, 1);
    tick();
    chk("abort_single", abort_o, 0);
    chk("abort_no_valid", valid_o, 0);
    // overflow with no drain
    ready = 0;
    start(0);
    expect_frame(8'h11, 0, 1, 0, 0);
    sbyte(8'h11, 0);
    sbyte(8'h22, 0);
    chk("ovf_valid", valid_o, 1);
    chk("ovf_data_held", data_o, 8'h11);
    chk("ovf_set", overflow_o, 1);
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("ovf_clr", overflow_o, 0);
    ready = 1;
    tick();
    ready = 0;
    stop();
    // reload on the drain cycle
    start(0);
    expect_frame(8'h7F, 0, 1, 0, 0);
    sbyte(8'h7F, 0);
    chk("held_7f", data_o, 8'h7F);
    expect_frame(8'h80, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) sbit(b80[i]);
    ready = 1;
    bus.sda.value = 0;
    bus.scl.pos_edge = 1;
    tick();
    bus.scl.pos_edge = 0;
    ready = 0;
    chk("reload_valid", valid_o, 1);
    chk("reload_data", data_o, 8'h80);
    chk("reload_no_ovf", overflow_o, 0);
    ready = 1;
    tick();
    ready = 0;
    stop();
    chk("no_abort_after_frame", abort_o, 0);
    // enable drop mid-frame flushes but keeps overflow
    start(0);
    sbyte(8'h01, 0);
    sbyte(8'h02, 0);
    for (int i = 0; i < 4; i++) sbit(1'b0);
    enable = 0;
    tick();
    chk("disable_valid", valid_o, 0);
    chk("disable_ovf_kept", overflow_o, 1);
    chk("disable_no_abort", abort_o, 0);
    enable = 1;
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    ready = 1;
    start(0);
    expect_frame(8'h5A, 1, 1, 0, 0);
    sbyte(8'h5A, 1);
    stop();
    // reset mid-frame
    ready = 0;
    start(0);
    sbyte(8'h33, 0);
    for (int i = 0; i < 3; i++) sbit(1'b1);
    rst_n = 0;
    tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    rst_n = 1;
    ready = 1;
    start(0);
    expect_frame(8'hC3, 0, 1, 0, 0);
    sbyte(8'hC3, 0);
    stop();
    tick(); tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
